// File: rtl/hdmi_rx_frame_sink.sv
// hdmi_rx_frame_sink: locks to a parallel de/hs/vs + RGB video stream, tags
// active pixels with x/y coordinates and measures frame geometry.
// Optional macro HDMI_RX_GEOM_CHECK_EN builds the frame-error/geometry check
// that drives geom_err and makes locked follow frame quality.
module hdmi_rx_frame_sink #(
  parameter int unsigned H_RES = 64,
  parameter int unsigned V_RES = 64
) (
  input  logic        hdmi_clk,
  input  logic        hdmi_rst_n,
  input  logic        in_de,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [23:0] pix_rgb,
  output logic        sof,
  output logic        eol,
  output logic        frame_done,
  output logic [10:0] meas_width,
  output logic [10:0] meas_height,
  output logic        locked,
  output logic        geom_err
);

  typedef enum logic {ST_WAIT_VS, ST_ACTIVE} state_t;
  localparam logic [10:0] CNT_MAX = '1;

  state_t      r_state;
  logic        r_de, r_vs, r_de_d, r_vs_d;
  logic [23:0] r_rgb;
  logic [10:0] r_x, r_y, r_last_len;
  logic        r_cl_pend;
  logic [10:0] r_cl_w, r_cl_h;

  logic        w_vs_rise, w_de, w_de_rise, w_de_fall, w_active;
  logic [10:0] w_px_x, w_x_next, w_y_next, w_cl_w, w_cl_h;

  // Input register stage plus previous-vs for edge detection
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      r_de   <= 1'b0;
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_de   <= in_de;
      r_vs   <= in_vs;
      r_vs_d <= r_vs;
      r_rgb  <= {in_r, in_g, in_b};
    end
  end

  // Edge detection and counter arithmetic; a pixel coinciding with a vs rise
  // is masked out here so it never reaches the counters or the outputs
  always_comb begin
    w_vs_rise = r_vs & ~r_vs_d;
    w_de      = r_de & ~w_vs_rise;
    w_de_rise = w_de & ~r_de_d;
    w_de_fall = ~w_de & r_de_d;
    w_active  = (r_state == ST_ACTIVE);
    w_px_x    = w_de_rise ? '0 : r_x;
    w_x_next  = (w_px_x == CNT_MAX) ? CNT_MAX : w_px_x + 11'd1;
    w_y_next  = (r_y == CNT_MAX) ? CNT_MAX : r_y + 11'd1;
    // A line ending in the same cycle as the vs rise still belongs to the closing frame
    w_cl_h    = w_de_fall ? w_y_next : r_y;
    w_cl_w    = w_de_fall ? r_x : r_last_len;
  end

  // Frame-lock FSM with pixel/line counters and frame-close capture
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      r_state    <= ST_WAIT_VS;
      r_de_d     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_last_len <= '0;
      r_cl_pend  <= 1'b0;
      r_cl_w     <= '0;
      r_cl_h     <= '0;
    end else begin
      r_de_d    <= w_de;
      r_cl_pend <= 1'b0;
      case (r_state)
        ST_WAIT_VS: begin
          if (w_vs_rise) begin
            r_state    <= ST_ACTIVE;
            r_x        <= '0;
            r_y        <= '0;
            r_last_len <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_vs_rise) begin
            r_cl_pend  <= 1'b1;
            r_cl_w     <= w_cl_w;
            r_cl_h     <= w_cl_h;
            r_x        <= '0;
            r_y        <= '0;
            r_last_len <= '0;
          end else begin
            if (w_de) r_x <= w_x_next;
            if (w_de_fall) begin
              r_last_len <= r_x;
              r_y        <= w_y_next;
            end
          end
        end
        default: r_state <= ST_WAIT_VS;
      endcase
    end
  end

  // Pixel output register; eol looks one cycle ahead at the raw de input
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      pix_valid <= w_de & w_active;
      pix_x     <= w_px_x;
      pix_y     <= r_y;
      pix_rgb   <= r_rgb;
      sof       <= w_de & w_active & (w_px_x == '0) & (r_y == '0);
      eol       <= w_de & w_active & ~in_de;
    end
  end

  // Frame-close outputs: pulse and measured geometry
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      frame_done  <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
    end else begin
      frame_done <= r_cl_pend;
      if (r_cl_pend) begin
        meas_width  <= r_cl_w;
        meas_height <= r_cl_h;
      end
    end
  end

`ifdef HDMI_RX_GEOM_CHECK_EN
  localparam logic [10:0] LP_H_RES = 11'(H_RES);
  localparam logic [10:0] LP_V_RES = 11'(V_RES);

  logic        r_hs, r_ferr, r_cl_err;
  logic [10:0] r_first_len;
  logic        w_err_now, w_geom_bad;

  // hs only matters for the de-during-hs error
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) r_hs <= 1'b0;
    else             r_hs <= in_hs;
  end

  // Per-cycle error sources and the frame-close verdict
  always_comb begin
    w_err_now  = (w_de & (w_px_x == CNT_MAX))
               | (w_de_fall & ((r_y == CNT_MAX) | ((r_y != '0) & (r_x != r_first_len))))
               | (r_de & r_hs)
               | (r_de & w_vs_rise);
    w_geom_bad = r_cl_err | (r_cl_w != LP_H_RES) | (r_cl_h != LP_V_RES);
  end

  // Frame error flag: accumulates within a frame, snapshotted at close
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      r_ferr      <= 1'b0;
      r_cl_err    <= 1'b0;
      r_first_len <= '0;
    end else if (w_vs_rise) begin
      r_cl_err    <= r_ferr | w_err_now | (w_cl_h == '0);
      r_ferr      <= ~w_active & w_err_now;
      r_first_len <= '0;
    end else if (w_active) begin
      if (w_err_now) r_ferr <= 1'b1;
      if (w_de_fall && (r_y == '0)) r_first_len <= r_x;
    end
  end

  // Status follows the quality of the last closed frame
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      geom_err <= 1'b0;
      locked   <= 1'b0;
    end else if (r_cl_pend) begin
      geom_err <= w_geom_bad;
      locked   <= ~w_geom_bad;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, in_hs, 11'(H_RES), 11'(V_RES)};
  assign geom_err = 1'b0;

  // Lock is sticky from the first closed frame until reset
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n)    locked <= 1'b0;
    else if (r_cl_pend) locked <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_hdmi_rx_frame_sink.sv
// Testbench for hdmi_rx_frame_sink: a table of frame descriptors is driven
// with random pixel data; expected pixels and frame-close records are queued
// by a stream-level model and compared against the DUT outputs.
module tb_hdmi_rx_frame_sink;
  localparam int H = 64;
  localparam int V = 64;

  logic        hdmi_clk = 1'b0;
  logic        hdmi_rst_n = 1'b0;
  logic        in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic        pix_valid, sof, eol, frame_done, locked, geom_err;
  logic [10:0] pix_x, pix_y, meas_width, meas_height;
  logic [23:0] pix_rgb;

  hdmi_rx_frame_sink #(.H_RES(H), .V_RES(V)) u_dut (
    .hdmi_clk(hdmi_clk), .hdmi_rst_n(hdmi_rst_n),
    .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .sof(sof), .eol(eol), .frame_done(frame_done),
    .meas_width(meas_width), .meas_height(meas_height),
    .locked(locked), .geom_err(geom_err)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  int cyc = 0;
  always @(posedge hdmi_clk) cyc <= cyc + 1;

  typedef struct { int x; int y; logic [23:0] rgb; bit sof; bit eol; int c; } px_t;
  typedef struct { int w; int h; bit geom; bit lck; int npix; int c; } fr_t;
  typedef struct {
    int w; int h; int short_line; int short_len; int gap; bit de_close;
    int exp_w; int exp_h; bit exp_ferr; int exp_npix;
  } row_t;

  px_t  pxq[$];
  fr_t  frq[$];
  px_t  e;
  fr_t  f;
  fr_t  pend;
  bit   pend_v = 0;
  bit   synced = 0;
  int   obs_pix = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  row_t tbl[7];

  function automatic void chk(input string nm, input bit ok, input string detail);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: %s", nm, detail);
    end
  endfunction

  function automatic fr_t make_fr(input int w, input int h, input bit ferr, input int npix);
    fr_t r;
    r.w = w; r.h = h; r.npix = npix; r.c = 0;
`ifdef HDMI_RX_GEOM_CHECK_EN
    r.geom = ferr || (w != H) || (h != V);
    r.lck  = !r.geom;
`else
    r.geom = 1'b0;
    r.lck  = 1'b1;
`endif
    return r;
  endfunction

  function automatic bit hs_at(input int k, input int g);
    return (g >= 4) && ((k == g / 2 - 1) || (k == g / 2));
  endfunction

  // One input cycle; active pixels of a synced frame go into the expected queue
  task automatic drive(input bit d, input bit h, input bit v, input bit push,
                       input int x, input int y, input int len);
    @(negedge hdmi_clk);
    in_de = d; in_hs = h; in_vs = v;
    in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
    if (d && push && synced)
      pxq.push_back('{x: x, y: y, rgb: {in_r, in_g, in_b},
                      sof: (x == 0 && y == 0), eol: (x == len - 1), c: cyc});
  endtask

  task automatic blank_lines(input int n, input int L, input bit v);
    for (int i = 0; i < n * L; i++)
      drive(1'b0, ((i % L) == 8) || ((i % L) == 9), v, 1'b0, 0, 0, 0);
  endtask

  task automatic active_line(input int len, input int y, input int gap);
    for (int x = 0; x < len; x++) drive(1'b1, 1'b0, 1'b0, 1'b1, x, y, len);
    for (int k = 0; k < gap; k++) drive(1'b0, hs_at(k, gap), 1'b0, 1'b0, 0, 0, 0);
  endtask

  // vs rise closes the pending frame (if any) and opens a new one
  task automatic drive_vs(input bit de_hi);
    drive(de_hi, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    if (pend_v) begin
      pend.c = cyc;
      frq.push_back(pend);
      pend_v = 0;
    end
    synced = 1;
    blank_lines(4, 82, 1'b1);
  endtask

  task automatic drive_body(input row_t r);
    int len, g;
    blank_lines(2, r.w + 18, 1'b0);
    for (int y = 0; y < r.h; y++) begin
      len = (y == r.short_line) ? r.short_len : r.w;
      g   = (r.gap > 0) ? r.gap : int'($urandom_range(1, 18));
      active_line(len, y, g);
    end
    blank_lines(2, r.w + 18, 1'b0);
    pend   = make_fr(r.exp_w, r.exp_h, r.exp_ferr, r.exp_npix);
    pend_v = synced;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {pix_valid, pix_x, pix_y, pix_rgb, sof, eol, frame_done,
             meas_width, meas_height, locked, geom_err} == '0,
        $sformatf("valid=%0b x=%0d y=%0d rgb=%06h sof=%0b eol=%0b fd=%0b w=%0d h=%0d lock=%0b gerr=%0b, required all 0",
                  pix_valid, pix_x, pix_y, pix_rgb, sof, eol, frame_done,
                  meas_width, meas_height, locked, geom_err));
  endtask

  // Output monitor: pixels and frame closes against the expected queues
  always @(negedge hdmi_clk) begin
    if (hdmi_rst_n) begin
      while (pxq.size() > 0 && pxq[0].c + 2 < cyc) begin
        chk("pix_missing", 1'b0, $sformatf("pix_valid=0, required pixel x=%0d y=%0d", pxq[0].x, pxq[0].y));
        void'(pxq.pop_front());
      end
      if (pix_valid) begin
        obs_pix++;
        if (pxq.size() == 0) begin
          chk("pix_unexpected", 1'b0, $sformatf("pix_valid=1 x=%0d y=%0d, required pix_valid=0", pix_x, pix_y));
        end else begin
          e = pxq.pop_front();
          chk("pix", (pix_x == 11'(e.x)) && (pix_y == 11'(e.y)) && (pix_rgb == e.rgb) &&
                     (sof == e.sof) && (eol == e.eol) && (cyc == e.c + 2),
              $sformatf("x=%0d y=%0d rgb=%06h sof=%0b eol=%0b t=%0d, required x=%0d y=%0d rgb=%06h sof=%0b eol=%0b t=%0d",
                        pix_x, pix_y, pix_rgb, sof, eol, cyc, e.x, e.y, e.rgb, e.sof, e.eol, e.c + 2));
        end
      end else begin
        chk("idle_flags", !sof && !eol, $sformatf("sof=%0b eol=%0b without pix_valid, required 0", sof, eol));
      end
      while (frq.size() > 0 && frq[0].c + 3 < cyc) begin
        chk("frame_missing", 1'b0, $sformatf("frame_done=0, required pulse at t=%0d", frq[0].c + 3));
        void'(frq.pop_front());
      end
      if (frame_done) begin
        if (frq.size() == 0) begin
          chk("frame_unexpected", 1'b0, $sformatf("frame_done=1 at t=%0d, required 0", cyc));
        end else begin
          f = frq.pop_front();
          chk("frame", (meas_width == 11'(f.w)) && (meas_height == 11'(f.h)) &&
                       (geom_err == f.geom) && (locked == f.lck) && (cyc == f.c + 3),
              $sformatf("w=%0d h=%0d gerr=%0b lock=%0b t=%0d, required w=%0d h=%0d gerr=%0b lock=%0b t=%0d",
                        meas_width, meas_height, geom_err, locked, cyc, f.w, f.h, f.geom, f.lck, f.c + 3));
          chk("frame_pixcount", obs_pix == f.npix,
              $sformatf("pixels=%0d, required %0d", obs_pix, f.npix));
        end
        obs_pix = 0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{w:64, h:64, short_line:-1, short_len:0,  gap:18, de_close:0, exp_w:64, exp_h:64, exp_ferr:0, exp_npix:4096};
    tbl[1] = '{w:64, h:64, short_line:10, short_len:63, gap:18, de_close:0, exp_w:64, exp_h:64, exp_ferr:1, exp_npix:4095};
    tbl[2] = '{w:64, h:64, short_line:-1, short_len:0,  gap:1,  de_close:0, exp_w:64, exp_h:64, exp_ferr:0, exp_npix:4096};
    tbl[3] = '{w:64, h:64, short_line:-1, short_len:0,  gap:0,  de_close:1, exp_w:64, exp_h:64, exp_ferr:1, exp_npix:4096};
    tbl[4] = '{w:32, h:48, short_line:-1, short_len:0,  gap:18, de_close:0, exp_w:32, exp_h:48, exp_ferr:0, exp_npix:1536};
    tbl[5] = '{w:64, h:0,  short_line:-1, short_len:0,  gap:18, de_close:0, exp_w:0,  exp_h:0,  exp_ferr:1, exp_npix:0};
    tbl[6] = '{w:64, h:64, short_line:-1, short_len:0,  gap:18, de_close:0, exp_w:64, exp_h:64, exp_ferr:0, exp_npix:4096};

    hdmi_rst_n = 1'b0;
    repeat (3) @(negedge hdmi_clk);
    #1 chk_all_zero("reset_state");
    @(negedge hdmi_clk);
    hdmi_rst_n = 1'b1;

    // Activity before the first vs must be ignored
    active_line(64, 0, 18);
    active_line(64, 1, 18);
    blank_lines(1, 82, 1'b0);

    drive_vs(1'b0);
    for (int i = 0; i < 7; i++) begin
      drive_body(tbl[i]);
      drive_vs(tbl[i].de_close);
    end

    // Reset while pixel (20,30) is being driven
    blank_lines(2, 82, 1'b0);
    for (int y = 0; y < 30; y++) active_line(64, y, 18);
    for (int x = 0; x <= 20; x++) drive(1'b1, 1'b0, 1'b0, 1'b1, x, 30, 64);
    #2 hdmi_rst_n = 1'b0;
    #1 chk_all_zero("reset_midframe");
    pxq.delete();
    frq.delete();
    synced  = 0;
    pend_v  = 0;
    obs_pix = 0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    hdmi_rst_n = 1'b1;
    for (int y = 31; y < 34; y++) active_line(64, y, 18);
    blank_lines(2, 82, 1'b0);
    drive_vs(1'b0);
    drive_body(tbl[0]);
    drive_vs(1'b0);
    blank_lines(1, 82, 1'b0);

    chk("drain", (pxq.size() == 0) && (frq.size() == 0),
        $sformatf("pending pixels=%0d frames=%0d, required 0/0", pxq.size(), frq.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hdmi_rx_frame_sink.md
# hdmi_rx_frame_sink

Receive-side counterpart of the team's HDMI/VGA-style pixel source. It consumes a parallel video stream (`de`/`hs`/`vs` plus 8-bit RGB) clocked by `hdmi_clk`, locks to frame boundaries and tags every active pixel with its x/y coordinate. It also measures the active frame geometry and flags frames that do not match the configured resolution. It sits between the video input pins (or the source model in simulation) and downstream image-processing or capture logic.

## Interface
- `H_RES`, 64, expected active pixels per line.
- `V_RES`, 64, expected active lines per frame.

- `hdmi_clk`  in  1  pixel clock; all logic on the rising edge.
- `hdmi_rst_n`  in  1  asynchronous, active-low reset.
- `in_de`  in  1  data enable, high during active pixels.
- `in_hs`  in  1  horizontal sync, active-high pulse.
- `in_vs`  in  1  vertical sync, active-high pulse.
- `in_r`, `in_g`, `in_b`  in  8 each  pixel components.
- `pix_valid`  out  1  active pixel present on the pixel outputs.
- `pix_x`, `pix_y`  out  11 each  coordinate of the current pixel.
- `pix_rgb`  out  24  {r,g,b}.
- `sof`  out  1  with `pix_valid`; marks pixel (0,0).
- `eol`  out  1  with `pix_valid`; marks the last pixel of a line.
- `frame_done`  out  1  one-cycle pulse when a frame is closed.
- `meas_width`, `meas_height`  out  11 each  geometry of the last closed frame.
- `locked`  out  1  stream is aligned and the last frame was good.
- `geom_err`  out  1  sticky per frame; set while the last closed frame was bad.

## Operation
- **Input stage.** All inputs are registered once. Edge detection (`de` rise/fall, `vs` rise) uses the registered value and its previous value.
- **State machine.**
  - `WAIT_VS`, entered at reset: all pixels are ignored.
  - `WAIT_VS` → `ACTIVE` on the first `vs` rising edge.
  - `ACTIVE` stays in `ACTIVE` on every later `vs` rise. Each such rise closes the current frame and opens a new one.
- **Counters.**
  - x resets to 0 on a `de` rising edge and increments on each `de`-high cycle.
  - When `de` falls, the line length is latched and the line counter increments.
  - y equals the line counter.
  - Both counters are 11 bits and saturate at 2047. Saturation sets the frame-error flag.
- **`eol` look-ahead.** `eol` is produced from the `de` fall detected one cycle early, using the one-cycle look-ahead that the output register provides.
- **Frame close** (`vs` rise in `ACTIVE`):
  - `meas_height` = line count.
  - `meas_width` = length of the last line.
  - `frame_done` pulses.
  - The line counter clears.
  - `frame_done` does not pulse for the `vs` that exits `WAIT_VS`.
- **Frame error.** Set by any of:
  - a line whose length ≠ the length of the first line of the frame;
  - counter saturation;
  - `de` high in the same cycle as a `vs` rise. That pixel is dropped.
  - `de` high while `hs` is high.
- **Reset mid-frame.** All state returns to `WAIT_VS`. There is no `pix_valid` until after the next `vs` rise.

## Timing
- Reset values: every output is 0, state is `WAIT_VS`, and all counters are 0.
- Latency: 2 cycles from `in_*` to `pix_*`, namely the input register plus the output register. `sof` and `eol` are aligned with their pixel.
- `frame_done`, `meas_*`, `locked` and `geom_err` update 2 cycles after the registered `vs` rise is seen, which is 3 cycles after `in_vs` rises. All four update in the same cycle.
- Back-to-back lines with a single `de`-low cycle between them must be handled.
- A frame with 0 lines closes with `meas_height`=0, `meas_width`=0 and an error.

## Configuration
- `HDMI_RX_GEOM_CHECK_EN` defined:
  - At frame close, `geom_err` = frame error OR `meas_width`≠`H_RES` OR `meas_height`≠`V_RES`.
  - `locked` = !`geom_err`, and is cleared immediately on the error.
- `HDMI_RX_GEOM_CHECK_EN` undefined:
  - The comparison logic is not built and `geom_err` is tied to 0.
  - `locked` goes to 1 at the first `frame_done` and returns to 0 only on reset.
  - Measurement still runs.

## Test plan
- **Nominal stream.** Nominal 64×64 stream from the team's source model (front/back porch 8, `hs` 2, `vs` 4). At the second `vs` rise, `frame_done` pulses with `meas_width`=64, `meas_height`=64, `locked`=1 and `geom_err`=0. The pixel count per frame is exactly 4096.
- **Coordinates.** The first pixel after the first `vs` has `sof`=1 with x=0, y=0. The pixel with x=63 has `eol`=1. The last pixel is at (63,63). `pix_rgb` equals the driven RGB, delayed 2 cycles.
- **Short line.** Line 10 is driven with 63 pixels. At close, `geom_err`=1 and `locked`=0. The next clean frame restores `locked`=1 and `geom_err`=0 (macro defined).
- **`de` during `vs`.** `de` is forced high in the cycle `vs` rises. That pixel has no `pix_valid` and the frame is flagged `geom_err`=1.
- **Reset mid-frame.** `hdmi_rst_n` is pulsed at (20,30). All outputs are 0 immediately. There is no `pix_valid` until after the next `vs` rise, and the following `frame_done` reports 64/64.
- **Macro undefined.** A 32×48 stream gives `meas_width`=32, `meas_height`=48, `geom_err`=0, and `locked`=1 after the first `frame_done`.
